lwc_seg_packer: RTL and testbench

Parametrised LWC-API segment source that turns segment commands plus a byte stream into header-framed words on a BUSW-wide valid/ready bus. It generalises the hand-built PDI/SDI FIFO stimulus: any bus width, arbitrary segment lengths, instruction words, EOI/EOT/Last flags, zero-padded tails and full output backpressure. It feeds the `pdi_data`/`sdi_data` inputs of `LWC` in benches and the host-side interface in FPGA wrappers.

---
 rtl/lwc_seg_packer.sv | 231 +++++++++++++++++++++++
 tb/tb_lwc_seg_packer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lwc_seg_packer.sv
// lwc_seg_packer: converts LWC segment commands plus a byte stream into
// header-framed BUSW-wide beats on a valid/ready output bus.
//
// state  | meaning
// S_IDLE | waiting for a command; the output register may still hold a beat
// S_HDR  | emitting the remaining header beats, MSB first
// S_DATA | gathering payload bytes into words, right-padding the tail
module lwc_seg_packer #(
    parameter int BUSW = 32,
    parameter int LENW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_instr,
    input  logic [3:0]      cmd_type,
    input  logic [3:0]      cmd_flags,
    input  logic [LENW-1:0] cmd_len,
    input  logic            cmd_last,
    input  logic [7:0]      din_data,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [BUSW-1:0] do_data,
    output logic            do_valid,
    input  logic            do_ready,
    output logic            do_last
);

    localparam int NB    = BUSW / 8;
    localparam int HB    = 32 / BUSW;
    localparam int LANEW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_hdr, w_hdr_nxt;
    logic [2:0]        r_hleft, w_hleft_nxt;
    logic              r_instr, w_instr_nxt;
    logic              r_last, w_last_nxt;
    logic [LENW-1:0]   r_len, w_len_nxt;
    logic [LENW-1:0]   r_rem, w_rem_nxt;
    logic [LANEW-1:0]  r_lane, w_lane_nxt;
    logic [BUSW-1:0]   r_gather, w_gather_nxt;
    logic              r_pend_valid, w_pend_valid_nxt;
    logic [BUSW-1:0]   r_pend_data, w_pend_data_nxt;
    logic              r_pend_final, w_pend_final_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [BUSW-1:0]   r_out_data, w_out_data_nxt;
    logic              r_out_last, w_out_last_nxt;

    logic              w_out_free;
    logic              w_byte_fire;
    logic              w_final;
    logic              w_word_done;
    logic [31:0]       w_hdr_word;
    logic [BUSW-1:0]   w_gather_fill;
    logic              w_hdr_go;
    logic [31:0]       w_hdr_src;
    logic [2:0]        w_hleft_src;
    logic              w_cur_instr;
    logic              w_cur_last;
    logic [LENW-1:0]   w_cur_len;
    logic              w_seg_end;

    assign cmd_ready = (r_state == S_IDLE);
    // rem guard keeps the counter from ever wrapping below zero
    assign din_ready = (r_state == S_DATA) && !r_pend_valid && (r_rem != '0);
    assign do_valid  = r_out_valid;
    assign do_data   = r_out_data;
    assign do_last   = r_out_last;

    assign w_out_free  = !r_out_valid || do_ready;
    assign w_byte_fire = din_valid && din_ready;
    assign w_final     = (r_rem == LENW'(1));
    assign w_word_done = (r_lane == LANEW'(NB - 1)) || w_final;
    assign w_hdr_word  = cmd_instr ? {cmd_type, 28'h0}
                                   : {cmd_type, cmd_flags, 8'h00, 16'(cmd_len)};

    always_comb begin
        w_gather_fill = r_gather;
        for (int k = 0; k < NB; k++) begin
            if (r_lane == LANEW'(k)) begin
                w_gather_fill[BUSW-1-8*k -: 8] = din_data;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_hdr_nxt        = r_hdr;
        w_hleft_nxt      = r_hleft;
        w_instr_nxt      = r_instr;
        w_last_nxt       = r_last;
        w_len_nxt        = r_len;
        w_rem_nxt        = r_rem;
        w_lane_nxt       = r_lane;
        w_gather_nxt     = r_gather;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_pend_final_nxt = r_pend_final;
        w_out_valid_nxt  = r_out_valid && !do_ready;
        w_out_data_nxt   = r_out_data;
        w_out_last_nxt   = r_out_last;
        w_hdr_go         = 1'b0;
        w_hdr_src        = r_hdr;
        w_hleft_src      = r_hleft;
        w_cur_instr      = r_instr;
        w_cur_last       = r_last;
        w_cur_len        = r_len;
        w_seg_end        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // first header beat is loaded on the accept edge itself
                if (cmd_valid) begin
                    w_instr_nxt = cmd_instr;
                    w_last_nxt  = cmd_last;
                    w_len_nxt   = cmd_len;
                    w_cur_instr = cmd_instr;
                    w_cur_last  = cmd_last;
                    w_cur_len   = cmd_len;
                    w_hdr_src   = w_hdr_word;
                    w_hleft_src = 3'(HB);
                    w_hdr_go    = 1'b1;
                end
            end
            S_HDR: begin
                w_hdr_go = 1'b1;
            end
            S_DATA: begin
                if (r_pend_valid) begin
                    if (w_out_free) begin
                        w_out_valid_nxt  = 1'b1;
                        w_out_data_nxt   = r_pend_data;
                        w_out_last_nxt   = r_last && r_pend_final;
                        w_pend_valid_nxt = 1'b0;
                        if (r_pend_final) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end else if (w_byte_fire) begin
                    w_rem_nxt  = r_rem - LENW'(1);
                    w_lane_nxt = r_lane + LANEW'(1);
                    if (w_word_done) begin
                        w_gather_nxt = '0;
                        w_lane_nxt   = '0;
                        if (w_out_free) begin
                            w_out_valid_nxt = 1'b1;
                            w_out_data_nxt  = w_gather_fill;
                            w_out_last_nxt  = r_last && w_final;
                            if (w_final) begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_pend_valid_nxt = 1'b1;
                            w_pend_data_nxt  = w_gather_fill;
                            w_pend_final_nxt = w_final;
                        end
                    end else begin
                        w_gather_nxt = w_gather_fill;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_hdr_go) begin
            w_seg_end = w_cur_instr || (w_cur_len == '0);
            if (w_out_free) begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_hdr_src[31 -: BUSW];
                w_hdr_nxt       = 32'({w_hdr_src, {BUSW{1'b0}}});
                w_hleft_nxt     = w_hleft_src - 3'd1;
                if (w_hleft_src == 3'd1) begin
                    w_out_last_nxt = w_cur_last && w_seg_end;
                    w_state_nxt    = w_seg_end ? S_IDLE : S_DATA;
                    w_rem_nxt      = w_cur_len;
                    w_lane_nxt     = '0;
                    w_gather_nxt   = '0;
                end else begin
                    w_out_last_nxt = 1'b0;
                    w_state_nxt    = S_HDR;
                end
            end else begin
                w_hdr_nxt   = w_hdr_src;
                w_hleft_nxt = w_hleft_src;
                w_state_nxt = S_HDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hdr        <= '0;
            r_hleft      <= '0;
            r_instr      <= 1'b0;
            r_last       <= 1'b0;
            r_len        <= '0;
            r_rem        <= '0;
            r_lane       <= '0;
            r_gather     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pend_final <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hdr        <= w_hdr_nxt;
            r_hleft      <= w_hleft_nxt;
            r_instr      <= w_instr_nxt;
            r_last       <= w_last_nxt;
            r_len        <= w_len_nxt;
            r_rem        <= w_rem_nxt;
            r_lane       <= w_lane_nxt;
            r_gather     <= w_gather_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_pend_final <= w_pend_final_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_last   <= w_out_last_nxt;
        end
    end

endmodule

// File: tb/tb_lwc_seg_packer.sv
// Bench for lwc_seg_packer: 32/16/8-bit instances, scoreboarded beats,
// directed framing cases, random backpressure/gaps and mid-segment reset.
module tb_lwc_seg_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_instr, cmd_last, din_valid, do_ready;
    logic [3:0]  cmd_type, cmd_flags;
    logic [15:0] cmd_len;
    logic [7:0]  din_data;
    int          sel;
    int          rmode;

    logic [2:0]  cr, dr, dv, dl;
    logic [31:0] dd32;
    logic [15:0] dd16;
    logic [7:0]  dd8;

    logic        m_cmd_ready, m_din_ready, m_valid, m_last;
    logic [31:0] m_data;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_pop_cyc = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  payload [0:63];
    logic        watch_din = 1'b0;
    logic        din_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lwc_seg_packer #(.BUSW(32), .LENW(16)) u_dut32 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && (sel == 0)), .cmd_ready(cr[0]),
        .cmd_instr(cmd_instr), .cmd_type(cmd_type), .cmd_flags(cmd_flags),
        .cmd_len(cmd_len), .cmd_last(cmd_last),
        .din_data(din_data), .din_valid(din_valid && (sel == 0)), .din_ready(dr[0]),
        .do_data(dd32), .do_valid(dv[0]), .do_ready(do_ready), .do_last(dl[0])
    );
    lwc_seg_packer #(.BUSW(16), .LENW(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && (sel == 1)), .cmd_ready(cr[1]),
        .cmd_instr(cmd_instr), .cmd_type(cmd_type), .cmd_flags(cmd_flags),
        .cmd_len(cmd_len), .cmd_last(cmd_last),
        .din_data(din_data), .din_valid(din_valid && (sel == 1)), .din_ready(dr[1]),
        .do_data(dd16), .do_valid(dv[1]), .do_ready(do_ready), .do_last(dl[1])
    );
    lwc_seg_packer #(.BUSW(8), .LENW(16)) u_dut8 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && (sel == 2)), .cmd_ready(cr[2]),
        .cmd_instr(cmd_instr), .cmd_type(cmd_type), .cmd_flags(cmd_flags),
        .cmd_len(cmd_len), .cmd_last(cmd_last),
        .din_data(din_data), .din_valid(din_valid && (sel == 2)), .din_ready(dr[2]),
        .do_data(dd8), .do_valid(dv[2]), .do_ready(do_ready), .do_last(dl[2])
    );

    always_comb begin
        case (sel)
            0: begin
                m_cmd_ready = cr[0]; m_din_ready = dr[0];
                m_valid = dv[0]; m_last = dl[0]; m_data = dd32;
            end
            1: begin
                m_cmd_ready = cr[1]; m_din_ready = dr[1];
                m_valid = dv[1]; m_last = dl[1]; m_data = {16'h0, dd16};
            end
            default: begin
                m_cmd_ready = cr[2]; m_din_ready = dr[2];
                m_valid = dv[2]; m_last = dl[2]; m_data = {24'h0, dd8};
            end
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int wid();
        return (sel == 0) ? 32 : ((sel == 1) ? 16 : 8);
    endfunction

    // ready pattern: 0 always ready, 1 stalled, 2 random 50%
    initial begin
        do_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0)      do_ready = 1'b1;
            else if (rmode == 1) do_ready = 1'b0;
            else                 do_ready = 1'($urandom_range(0, 1));
        end
    end

    // monitor: pops the scoreboard on each accepted beat, checks stall stability
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {31'h0, m_valid}, 32'h1);
                    check("stall_data", m_data, prev_data);
                    check("stall_last", {31'h0, m_last}, {31'h0, prev_last});
                end
                if (m_valid && do_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h with nothing expected", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e[31:0]);
                        check("beat_last", {31'h0, m_last}, {31'h0, e[32]});
                    end
                    last_pop_cyc = cyc;
                end
                prev_stall = m_valid && !do_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (watch_din && m_din_ready) din_seen = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic instr, input logic [3:0] typ, input logic [3:0] flags,
                            input logic [15:0] len, input logic last);
        int          w, nb, hb, nwords;
        logic [31:0] hw, mask, word;
        logic        has_data;
        w = wid();
        nb = w / 8;
        hb = 32 / w;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        hw = instr ? {typ, 28'h0} : {typ, flags, 8'h00, len};
        has_data = !instr && (len != 16'h0);
        for (int h = 0; h < hb; h++) begin
            word = (hw >> (32 - w * (h + 1))) & mask;
            exp_q.push_back({last && !has_data && (h == hb - 1), word});
        end
        if (has_data) begin
            nwords = (int'(len) + nb - 1) / nb;
            for (int wi = 0; wi < nwords; wi++) begin
                word = '0;
                for (int k = 0; k < nb; k++) begin
                    word = word << 8;
                    if (wi * nb + k < int'(len)) word[7:0] = payload[wi * nb + k];
                end
                exp_q.push_back({last && (wi == nwords - 1), word});
            end
        end
    endtask

    task automatic send_cmd(input logic instr, input logic [3:0] typ, input logic [3:0] flags,
                            input logic [15:0] len, input logic last);
        int n;
        cmd_instr = instr; cmd_type = typ; cmd_flags = flags;
        cmd_len = len; cmd_last = last; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_cmd_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: cmd_ready stayed %b", m_cmd_ready);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        din_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        din_data = b;
        din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_din_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL din_timeout: din_ready stayed %b", m_din_ready);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic run_seg(input logic instr, input logic [3:0] typ, input logic [3:0] flags,
                           input logic [15:0] len, input logic last, input int gapmax);
        push_exp(instr, typ, flags, len, last);
        send_cmd(instr, typ, flags, len, last);
        if (!instr) begin
            for (int i = 0; i < int'(len); i++) begin
                send_byte(payload[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b0; sel = 0; rmode = 0;
        cmd_valid = 1'b0; cmd_instr = 1'b0; cmd_type = '0; cmd_flags = '0;
        cmd_len = '0; cmd_last = 1'b0; din_valid = 1'b0; din_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'h0, m_cmd_ready}, 32'h1);
        check("rst_din_ready", {31'h0, m_din_ready}, 32'h0);
        check("rst_do_valid", {29'h0, dv}, 32'h0);
        check("rst_do_last", {29'h0, dl}, 32'h0);
        check("rst_do_data", m_data, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit bus, type 1 flags 2, 32 bytes, last set, continuous flow
        sel = 0;
        for (int i = 0; i < 32; i++) payload[i] = 8'(i);
        exp_q.push_back({1'b0, 32'h1200_0020});
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back({w == 7, 8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)});
        end
        send_cmd(1'b0, 4'h1, 4'h2, 16'd32, 1'b1);
        check("hdr_latency", {31'h0, m_valid}, 32'h1);
        for (int i = 0; i < 32; i++) send_byte(payload[i], 0);
        check("follow_on_cmd_ready", {31'h0, m_cmd_ready}, 32'h1);
        drain();
        check("data_rate_cycles", 32'(last_pop_cyc - acc_cyc), 32'd32);

        // 8-bit bus, instruction opcode 7 with last; length and flags ignored
        sel = 2;
        din_seen = 1'b0;
        watch_din = 1'b1;
        exp_q.push_back({1'b0, 32'h70});
        exp_q.push_back({1'b0, 32'h00});
        exp_q.push_back({1'b0, 32'h00});
        exp_q.push_back({1'b1, 32'h00});
        send_cmd(1'b1, 4'h7, 4'hF, 16'd5, 1'b1);
        drain();
        watch_din = 1'b0;
        check("instr_no_din_ready", {31'h0, din_seen}, 32'h0);

        // 16-bit bus, len 5, padded tail
        sel = 1;
        payload[0] = 8'hA1; payload[1] = 8'hA2; payload[2] = 8'hA3;
        payload[3] = 8'hA4; payload[4] = 8'hA5;
        exp_q.push_back({1'b0, 32'h3A00});
        exp_q.push_back({1'b0, 32'h0005});
        exp_q.push_back({1'b0, 32'hA1A2});
        exp_q.push_back({1'b0, 32'hA3A4});
        exp_q.push_back({1'b0, 32'hA500});
        send_cmd(1'b0, 4'h3, 4'hA, 16'd5, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(payload[i], 0);
        drain();

        // 32-bit bus, zero-length segment
        sel = 0;
        din_seen = 1'b0;
        watch_din = 1'b1;
        exp_q.push_back({1'b1, 32'h5400_0000});
        send_cmd(1'b0, 4'h5, 4'h4, 16'd0, 1'b1);
        check("len0_back_to_idle", {31'h0, m_cmd_ready}, 32'h1);
        drain();
        watch_din = 1'b0;
        check("len0_no_din_ready", {31'h0, din_seen}, 32'h0);

        // random segments with backpressure and byte gaps
        rmode = 2;
        for (int s = 0; s < 200; s++) begin
            logic        r_instr;
            logic [15:0] r_len;
            sel = (s / 20) % 3;
            r_instr = ($urandom_range(0, 9) == 0);
            r_len = 16'($urandom_range(0, 20));
            for (int i = 0; i < 64; i++) payload[i] = 8'($urandom_range(0, 255));
            run_seg(r_instr, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    r_len, 1'($urandom_range(0, 1)), 2);
            if ((s % 20) == 19) drain();
        end
        drain();

        // reset while a completed word is pending behind a stalled output
        rmode = 0;
        sel = 0;
        rmode = 1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send_cmd(1'b0, 4'h2, 4'h1, 16'd8, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 0);
        check("pend_din_ready", {31'h0, m_din_ready}, 32'h0);
        check("pend_do_valid", {31'h0, m_valid}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_do_valid", {31'h0, m_valid}, 32'h0);
        check("midrst_do_last", {31'h0, m_last}, 32'h0);
        check("midrst_do_data", m_data, 32'h0);
        check("midrst_cmd_ready", {31'h0, m_cmd_ready}, 32'h1);
        check("midrst_din_ready", {31'h0, m_din_ready}, 32'h0);
        rst = 1'b1;
        rmode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) payload[i] = 8'(8'h50 + i);
        exp_q.push_back({1'b0, 32'h6300_0006});
        exp_q.push_back({1'b0, 32'h5051_5253});
        exp_q.push_back({1'b1, 32'h5455_0000});
        send_cmd(1'b0, 4'h6, 4'h3, 16'd6, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(payload[i], 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
